// File: rtl/wb_ccff_loader.sv
// ---------------------------------------------------------------------------
// wb_ccff_loader
//
// Wishbone slave that takes 32-bit words from the management core and
// streams them MSB-first into the FPGA configuration flip-flop chain, one bit
// per ccff_shift_o pulse. It has a single-word buffer, so the core can queue
// the next word while the current one is shifting.
//
// Register window (wbs_adr_i[3:2]):
//   0x0 CTRL  W: bit0 enable, bit1 clear (self-clearing)
//             R: bit0 enable, bit1 busy, bit2 buf_full, bit3 done, bit8 last_tail
//   0x4 DATA  W: load word buffer   R: 0
//   0x8 LEN   R/W: total bits to program, 0 = unbounded
//   0xC COUNT R: bits shifted since the last clear
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     Wishbone request qualifiers
//   wbs_sel_i                byte selects (ignored, full-word accesses only)
//   wbs_adr_i, wbs_dat_i     address and write data
//   wbs_ack_o, wbs_dat_o     one-cycle acknowledge and read data
//   ccff_head_o              serial data into the chain head
//   ccff_shift_o             one-cycle shift enable to the chain
//   ccff_tail_i              chain tail, captured on every shift pulse
//   prog_done_o              LEN bits have been shifted
// ---------------------------------------------------------------------------
module wb_ccff_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DIV       = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ccff_head_o,
  output logic        ccff_shift_o,
  input  logic        ccff_tail_i,
  output logic        prog_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      state, next_state;
  logic        enable, buf_full, last_tail;
  logic [31:0] buffer, shreg, len_reg, count;
  logic [4:0]  bitidx, next_bitidx;
  logic [7:0]  divcnt, next_divcnt;
  logic [31:0] next_shreg;

  logic        hit, accept, wr, rd;
  logic        ctrl_wr, data_wr, len_wr;
  logic        clear, disable_wr, pulse, busy;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;

  // Byte selects and the low address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

  // Request decode. A DATA write is held off (no ack) while the buffer is
  // still occupied; everything else is accepted as soon as it is presented.
  always_comb begin
    reg_sel    = wbs_adr_i[3:2];
    hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    accept     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && hit &&
                 !(wbs_we_i && (reg_sel == 2'd1) && buf_full);
    wr         = accept && wbs_we_i;
    rd         = accept && !wbs_we_i;
    ctrl_wr    = wr && (reg_sel == 2'd0);
    data_wr    = wr && (reg_sel == 2'd1);
    len_wr     = wr && (reg_sel == 2'd2);
    clear      = ctrl_wr && wbs_dat_i[1];
    disable_wr = ctrl_wr && !wbs_dat_i[0];
    pulse      = (state == SHIFT) && (divcnt == DIV_LAST);
    busy       = (state == LOAD) || (state == SHIFT);
  end

  // Read data mux, sampled at acceptance and presented during the ack cycle.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {23'd0, last_tail, 4'd0, (state == DONE), buf_full, busy, enable};
      2'd1: rdata = '0;
      2'd2: rdata = len_reg;
      default: rdata = count;
    endcase
  end

  // Shift engine next-state logic. The shift pulse still completes its bit
  // in the cycle an abort arrives, because ccff_shift_o is already high then;
  // the abort only redirects the state.
  always_comb begin
    next_state  = state;
    next_shreg  = shreg;
    next_bitidx = bitidx;
    next_divcnt = divcnt;
    case (state)
      IDLE: begin
        if (enable && buf_full) next_state = LOAD;
      end
      LOAD: begin
        next_state  = SHIFT;
        next_shreg  = buffer;
        next_bitidx = '0;
        next_divcnt = '0;
      end
      SHIFT: begin
        if (pulse) begin
          next_shreg  = {shreg[30:0], 1'b0};
          next_bitidx = bitidx + 5'd1;
          next_divcnt = '0;
          if ((len_reg != '0) && ((count + 32'd1) == len_reg)) begin
            next_state = DONE;
          end else if (bitidx == 5'd31) begin
            next_state = buf_full ? LOAD : IDLE;
          end
        end else begin
          next_divcnt = divcnt + 8'd1;
        end
      end
      default: begin
      end
    endcase
    if (clear || disable_wr) next_state = IDLE;
  end

  // Engine and register state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      shreg     <= '0;
      bitidx    <= '0;
      divcnt    <= '0;
      enable    <= 1'b0;
      buf_full  <= 1'b0;
      buffer    <= '0;
      len_reg   <= '0;
      count     <= '0;
      last_tail <= 1'b0;
    end else begin
      state  <= next_state;
      shreg  <= next_shreg;
      bitidx <= next_bitidx;
      divcnt <= next_divcnt;
      if (ctrl_wr) enable <= wbs_dat_i[0];
      if (len_wr) len_reg <= wbs_dat_i;
      // The buffer only empties when its word really moves into the shift
      // register; an aborted LOAD leaves it in place.
      if (data_wr) begin
        buffer   <= wbs_dat_i;
        buf_full <= 1'b1;
      end else if ((state == LOAD) && (next_state == SHIFT)) begin
        buf_full <= 1'b0;
      end
      if (clear) begin
        count <= '0;
      end else if (pulse) begin
        count <= count + 32'd1;
      end
      if (pulse) last_tail <= ccff_tail_i;
    end
  end

  // Outputs are registered from the next-state values so each one lines up
  // with the state it describes, without any combinational path to a pin.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      ccff_head_o  <= 1'b0;
      ccff_shift_o <= 1'b0;
      prog_done_o  <= 1'b0;
    end else begin
      wbs_ack_o    <= accept;
      wbs_dat_o    <= rd ? rdata : 32'd0;
      ccff_head_o  <= (next_state == SHIFT) ? next_shreg[31] : 1'b0;
      ccff_shift_o <= (next_state == SHIFT) && (next_divcnt == DIV_LAST);
      prog_done_o  <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_wb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_wb_ccff_loader
//
// Directed bench for wb_ccff_loader. Two instances share one Wishbone bus at
// different base addresses: u_dut1 (DIV=1) at 0x3000_0000 and u_dut3 (DIV=3)
// at 0x3000_0010, so each only answers its own window. A negedge monitor
// logs every shift pulse (cycle number and head bit) per instance, and a
// small 8-stage chain model drives u_dut1's tail during the loopback test.
// ---------------------------------------------------------------------------
module tb_wb_ccff_loader;

  localparam logic [31:0] A1 = 32'h3000_0000;
  localparam logic [31:0] A3 = 32'h3000_0010;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack1, ack3, head1, head3, shift1, shift3, done1, done3;
  logic [31:0] rdat1, rdat3;
  logic        tail1, tail3;
  logic        loop_en;
  logic [7:0]  chain1;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  int           p1_cnt = 0, p3_cnt = 0;
  logic [127:0] p1_hist = '0, p3_hist = '0;
  int           p1_cyc [1024];
  int           p3_cyc [1024];

  wb_ccff_loader #(.BASE_ADDR(A1), .DIV(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack1), .wbs_dat_o(rdat1),
    .ccff_head_o(head1), .ccff_shift_o(shift1), .ccff_tail_i(tail1),
    .prog_done_o(done1)
  );

  wb_ccff_loader #(.BASE_ADDR(A3), .DIV(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack3), .wbs_dat_o(rdat3),
    .ccff_head_o(head3), .ccff_shift_o(shift3), .ccff_tail_i(tail3),
    .prog_done_o(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Downstream chain model: tail is the head bit from eight pulses earlier.
  initial chain1 = '0;
  always @(posedge clk) if (shift1) chain1 <= {chain1[6:0], head1};
  assign tail1 = loop_en & chain1[7];
  assign tail3 = 1'b0;

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (shift1) begin
      p1_cyc[p1_cnt % 1024] <= cycle;
      p1_hist <= {p1_hist[126:0], head1};
      p1_cnt  <= p1_cnt + 1;
    end
    if (shift3) begin
      p3_cyc[p3_cnt % 1024] <= cycle;
      p3_hist <= {p3_hist[126:0], head3};
      p3_cnt  <= p3_cnt + 1;
    end
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One Wishbone access, bounded by 'limit' cycles. Called #1 after a posedge.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input int limit, output logic [31:0] rdv, output int ac,
                     output bit ok);
    adr = a; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    ok = 1'b0; rdv = '0; ac = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (ack1 | ack3) begin
        ok = 1'b1; rdv = rdat1 | rdat3; ac = cycle;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int ac);
    logic [31:0] junk;
    bit ok;
    bus(a, 1'b1, d, 200, junk, ac, ok);
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL bus_write_ack: addr %h got no ack, required ack", a);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    int ac;
    bit ok;
    bus(a, 1'b0, 32'd0, 200, d, ac, ok);
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL bus_read_ack: addr %h got no ack, required ack", a);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b1; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; wdat = '0;
    loop_en = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack1, ack3, head1, head3, shift1, shift3, done1, done3} !== 8'd0 ||
        (rdat1 | rdat3) !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b/%h, required 0/0",
               {ack1, ack3, head1, head3, shift1, shift3, done1, done3}, rdat1 | rdat3);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      rd(A1 + 32'(r * 4), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: got %h, required 00000000", r, d);
      end
      @(posedge clk); #1;
      checks++;
      if ((ack1 | ack3) !== 1'b0 || (rdat1 | rdat3) !== 32'd0) begin
        errors++;
        $display("[TB] FAIL ack_one_cycle%0d: got ack=%b dat=%h, required 0/0",
                 r, ack1 | ack3, rdat1 | rdat3);
      end
    end
    rd(A3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl_dut3: got %h, required 00000000", d);
    end
  endtask

  task automatic test_single_word;
    int a, c0;
    logic [31:0] d;
    wr(A1, 32'h1, a);
    c0 = p1_cnt;
    wr(A1 + 4, 32'hA5A5_0F0F, a);
    wait_cycles(40);
    checks++;
    if (p1_cnt - c0 != 32) begin
      errors++; $display("[TB] FAIL single_pulses: got %0d, required 32", p1_cnt - c0);
    end
    checks++;
    if (p1_cyc[c0 % 1024] != a + 2) begin
      errors++; $display("[TB] FAIL single_first_cycle: got %0d, required %0d", p1_cyc[c0 % 1024], a + 2);
    end
    checks++;
    if (p1_cyc[(c0 + 31) % 1024] != a + 33) begin
      errors++; $display("[TB] FAIL single_last_cycle: got %0d, required %0d", p1_cyc[(c0 + 31) % 1024], a + 33);
    end
    checks++;
    if (p1_hist[31:0] !== 32'hA5A5_0F0F) begin
      errors++; $display("[TB] FAIL single_head_bits: got %h, required a5a50f0f", p1_hist[31:0]);
    end
    checks++;
    if (head1 !== 1'b0) begin
      errors++; $display("[TB] FAIL single_head_idle: got %b, required 0", head1);
    end
    rd(A1 + 12, d);
    checks++;
    if (d !== 32'd32) begin
      errors++; $display("[TB] FAIL single_count: got %0d, required 32", d);
    end
    rd(A1, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("[TB] FAIL single_ctrl: got %h, required 00000001", d);
    end
  endtask

  task automatic test_back_to_back;
    int ab, ac, ad, c0;
    logic [31:0] d;
    c0 = p1_cnt;
    wr(A1 + 4, 32'h1234_5678, ab);
    wr(A1 + 4, 32'hDEAD_BEEF, ac);
    wr(A1 + 4, 32'h0F1E_2D3C, ad);
    checks++;
    if (ac != ab + 3) begin
      errors++; $display("[TB] FAIL b2b_second_ack: got %0d, required %0d", ac, ab + 3);
    end
    checks++;
    if (ad != ab + 36) begin
      errors++; $display("[TB] FAIL b2b_stalled_ack: got %0d, required %0d", ad, ab + 36);
    end
    wait_cycles(75);
    checks++;
    if (p1_cnt - c0 != 96) begin
      errors++; $display("[TB] FAIL b2b_pulses: got %0d, required 96", p1_cnt - c0);
    end
    checks++;
    if (p1_cyc[(c0 + 32) % 1024] != ab + 35 || p1_cyc[(c0 + 64) % 1024] != ab + 68 ||
        p1_cyc[(c0 + 95) % 1024] != ab + 99) begin
      errors++;
      $display("[TB] FAIL b2b_word_timing: got %0d/%0d/%0d, required %0d/%0d/%0d",
               p1_cyc[(c0 + 32) % 1024], p1_cyc[(c0 + 64) % 1024], p1_cyc[(c0 + 95) % 1024],
               ab + 35, ab + 68, ab + 99);
    end
    checks++;
    if (p1_hist[95:0] !== {32'h1234_5678, 32'hDEAD_BEEF, 32'h0F1E_2D3C}) begin
      errors++; $display("[TB] FAIL b2b_head_bits: got %h, required 12345678deadbeef0f1e2d3c", p1_hist[95:0]);
    end
    rd(A1 + 12, d);
    checks++;
    if (d !== 32'd128) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d, required 128", d);
    end
  endtask

  task automatic test_len;
    int a, a2, c0, x;
    logic [31:0] d;
    wr(A1, 32'h3, x);
    wr(A1 + 8, 32'd40, x);
    c0 = p1_cnt;
    wr(A1 + 4, 32'hFFFF_FFFF, a);
    wr(A1 + 4, 32'h8000_0000, a2);
    checks++;
    if (a2 != a + 3) begin
      errors++; $display("[TB] FAIL len_second_ack: got %0d, required %0d", a2, a + 3);
    end
    while (cycle < a + 42) begin @(posedge clk); #1; end
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("[TB] FAIL len_done_early: got %b, required 0", done1);
    end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b1) begin
      errors++; $display("[TB] FAIL len_done_rise: got %b, required 1", done1);
    end
    wait_cycles(10);
    checks++;
    if (p1_cnt - c0 != 40 || p1_hist[39:0] !== 40'hFF_FFFF_FF80) begin
      errors++; $display("[TB] FAIL len_pulses: got %0d bits %h, required 40 bits ffffffff80",
                         p1_cnt - c0, p1_hist[39:0]);
    end
    rd(A1 + 12, d);
    checks++;
    if (d !== 32'd40) begin
      errors++; $display("[TB] FAIL len_count: got %0d, required 40", d);
    end
    wr(A1 + 4, 32'h5555_5555, x);
    wait_cycles(50);
    checks++;
    if (p1_cnt - c0 != 40) begin
      errors++; $display("[TB] FAIL len_no_shift_in_done: got %0d pulses, required 40", p1_cnt - c0);
    end
    rd(A1, d);
    checks++;
    if (d !== 32'hD) begin
      errors++; $display("[TB] FAIL len_ctrl_done: got %h, required 0000000d", d);
    end
    wr(A1, 32'h2, x);
    wait_cycles(1);
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("[TB] FAIL len_clear_done: got %b, required 0", done1);
    end
    rd(A1 + 12, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("[TB] FAIL len_clear_count: got %0d, required 0", d);
    end
    rd(A1, d);
    checks++;
    if (d !== 32'h4) begin
      errors++; $display("[TB] FAIL len_clear_ctrl: got %h, required 00000004", d);
    end
    wr(A1 + 8, 32'd0, x);
  endtask

  task automatic test_disable;
    int a, b, c3, x;
    logic [31:0] d;
    wr(A3, 32'h1, x);
    c3 = p3_cnt;
    wr(A3 + 4, 32'hC3C3_3C3C, a);
    while (cycle < a + 16) begin @(posedge clk); #1; end
    wr(A3, 32'h0, x);
    wait_cycles(30);
    checks++;
    if (p3_cnt - c3 != 5 || p3_hist[4:0] !== 5'b11000) begin
      errors++; $display("[TB] FAIL disable_pulses: got %0d bits %b, required 5 bits 11000",
                         p3_cnt - c3, p3_hist[4:0]);
    end
    checks++;
    if (p3_cyc[(c3 + 1) % 1024] != a + 7) begin
      errors++; $display("[TB] FAIL div3_spacing: got %0d, required %0d", p3_cyc[(c3 + 1) % 1024], a + 7);
    end
    rd(A3 + 12, d);
    checks++;
    if (d !== 32'd5) begin
      errors++; $display("[TB] FAIL disable_count: got %0d, required 5", d);
    end
    rd(A3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL disable_ctrl: got %h, required 00000000", d);
    end
    wr(A3, 32'h1, x);
    c3 = p3_cnt;
    wr(A3 + 4, 32'h9000_0001, b);
    wait_cycles(106);
    checks++;
    if (p3_cnt - c3 != 32 || p3_cyc[c3 % 1024] != b + 4) begin
      errors++; $display("[TB] FAIL reenable_pulses: got %0d first at %0d, required 32 first at %0d",
                         p3_cnt - c3, p3_cyc[c3 % 1024], b + 4);
    end
    checks++;
    if (p3_hist[31:0] !== 32'h9000_0001) begin
      errors++; $display("[TB] FAIL reenable_bits: got %h, required 90000001", p3_hist[31:0]);
    end
    rd(A3 + 12, d);
    checks++;
    if (d !== 32'd37) begin
      errors++; $display("[TB] FAIL reenable_count: got %0d, required 37", d);
    end
  endtask

  task automatic test_loopback;
    int x;
    logic [31:0] d;
    logic [31:0] words [3];
    logic [31:0] exp_ctrl [3];
    words    = '{32'h0, 32'hFFFF_FEFF, 32'h0000_0100};
    exp_ctrl = '{32'h101, 32'h001, 32'h101};
    loop_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      if (w == 0) wr(A1, 32'h1, x);
      else        wr(A1 + 4, words[w], x);
      wait_cycles(45);
      rd(A1, d);
      checks++;
      if (d !== exp_ctrl[w]) begin
        errors++; $display("[TB] FAIL loopback_word%0d: got ctrl %h, required %h", w, d, exp_ctrl[w]);
      end
    end
    checks++;
    if (p1_hist[95:0] !== {32'h5555_5555, 32'hFFFF_FEFF, 32'h0000_0100}) begin
      errors++; $display("[TB] FAIL loopback_bits: got %h, required 55555555fffffeff00000100", p1_hist[95:0]);
    end
  endtask

  task automatic test_out_of_window;
    logic [31:0] d;
    int ac;
    bit ok;
    bus(32'h3000_0020, 1'b1, 32'hFFFF_FFFF, 10, d, ac, ok);
    checks++;
    if (ok !== 1'b0) begin
      errors++; $display("[TB] FAIL oow_write_ack: got ack, required none");
    end
    bus(32'h4000_0008, 1'b0, 32'd0, 10, d, ac, ok);
    checks++;
    if (ok !== 1'b0 || (rdat1 | rdat3) !== 32'd0) begin
      errors++; $display("[TB] FAIL oow_read_ack: got ack=%b dat=%h, required none/0", ok, rdat1 | rdat3);
    end
  endtask

  task automatic test_reset_mid;
    int a;
    logic [31:0] d;
    wr(A3 + 4, 32'hFFFF_FFFF, a);
    while (cycle < a + 10) begin @(posedge clk); #1; end
    checks++;
    if (shift3 !== 1'b1 || head3 !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_before_reset: got shift=%b head=%b, required 1/1", shift3, head3);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({shift3, head3, done3, ack3} !== 4'b0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %b, required 0000", {shift3, head3, done3, ack3});
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(A3 + 12, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_reset_count: got %0d, required 0", d);
    end
    rd(A3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_reset_ctrl: got %h, required 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_len();
    test_disable();
    test_loopback();
    test_out_of_window();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ccff_loader.md
# wb_ccff_loader

Wishbone slave inside `fpga_top` that consumes the caravel user-area Wishbone bus and streams 32-bit words written by the management core into the FPGA configuration flip-flop chain, one bit at a time. It owns the word buffer, the shift engine, the bit counter and the programming-complete flag. The configuration chain fabric sits directly downstream and latches one bit per `ccff_shift_o` pulse.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: register window base; decode uses `wbs_adr_i[31:4]` only.
- `DIV`, default 2: clock cycles per shifted bit; legal range 1..255.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `wbs_cyc_i` in 1: bus cycle.
- `wbs_stb_i` in 1: strobe.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte selects. Ignored; every access is a full word.
- `wbs_adr_i` in 32: address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge, one-cycle pulse.
- `wbs_dat_o` out 32: read data.
- `ccff_head_o` out 1: serial data into chain head.
- `ccff_shift_o` out 1: one-cycle shift enable to the chain.
- `ccff_tail_i` in 1: chain tail, for loopback check.
- `prog_done_o` out 1: programming complete.

## Operation
Register map (`adr[3:2]`):
- 0x0 CTRL.
  - Write: bit0 `enable`, bit1 `clear`. `clear` is self-clearing; it zeroes COUNT and `done` and forces IDLE.
  - Read: bit0 `enable`, bit1 `busy` (state≠IDLE/DONE), bit2 `buf_full`, bit3 `done`, bit8 `last_tail`.
- 0x4 DATA.
  - Write: loads the 1-word buffer and sets `buf_full`.
  - Read: returns 0.
- 0x8 LEN: read/write total bits to program. 0 means unbounded.
- 0xC COUNT: read-only, bits shifted since clear. Wraps at 2^32.

Bus behaviour:
- A request is accepted when `cyc&stb&!ack`, the address decode hits, and the access is not stalled.
- `wbs_ack_o` rises the cycle after acceptance and stays high for exactly one cycle.
- A DATA write while `buf_full=1` stalls with no ack until the buffer empties.
- Out-of-window addresses are never acked.
- `wbs_dat_o` is valid during ack and is 0 otherwise.

Shift FSM has four states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when `enable & buf_full`.
- LOAD, one cycle:
  - shreg ← buffer and `buf_full` ← 0.
  - `bitidx` ← 0.
  - `divcnt` ← 0.
- SHIFT:
  - `ccff_head_o` = shreg[31] (MSB-first).
  - `divcnt` counts 0..DIV-1.
  - When `divcnt`=DIV-1, in that same cycle: `ccff_shift_o`=1, `last_tail`←`ccff_tail_i`, shreg<<=1, COUNT+=1, `bitidx`+=1.
- Exit from SHIFT, evaluated on each shift pulse:
  - If LEN≠0 and COUNT+1=LEN → DONE. Any remaining bits of the word are discarded.
  - Else if `bitidx`=31 → LOAD if `buf_full`, otherwise IDLE.
- DONE: `prog_done_o`=1. DATA writes are still accepted into the buffer but are not shifted.
- Exiting DONE: `clear`, or `enable` written 0, → IDLE.
- `enable` written 0 during LOAD/SHIFT: → IDLE on the next edge. The partial word is dropped, COUNT is held, and the buffer is kept.
- `clear` and a DATA write in the same cycle are impossible, because there is one access per ack.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `ccff_head_o`=0, `ccff_shift_o`=0, `prog_done_o`=0.
  - State IDLE; `enable`=0, `buf_full`=0.
  - LEN=0, COUNT=0, shreg=0, `last_tail`=0.
- Reset mid-shift returns everything to these values immediately.
- `ccff_head_o` is 0 outside SHIFT.
- Worked timing, DATA write accepted in cycle 0 with `enable`=1:
  - Cycle 1: ack high, `buf_full`=1.
  - Cycle 2: LOAD.
  - Cycle 3: SHIFT begins.
  - First `ccff_shift_o` in cycle 3+DIV-1.
  - Shift pulses then repeat every DIV cycles.
- Word throughput: 32·DIV cycles plus 1 LOAD cycle.
- Back-to-back words: the buffer frees at LOAD, so a second word written during SHIFT causes no stall.
- `ccff_head_o` is stable for the full DIV-cycle window before and during its shift pulse.
- All outputs are registered.

## Test plan
- Reset check, then read all four registers → CTRL=0, DATA=0, LEN=0, COUNT=0; ack is exactly one cycle per access.
- DIV=1, `enable`=1, LEN=0, write DATA 0xA5A5_0F0F → 32 shift pulses in cycles 3..34, `ccff_head_o` sequence 1,0,1,0,0,1,0,1,… MSB-first; COUNT=32; state back to IDLE.
- Write two words back-to-back, then a third while `buf_full`=1 → the third write's ack is delayed until the first word's SHIFT ends and the second word's LOAD completes; then 64+32 pulses with 1-cycle gaps at each LOAD.
- LEN=40, write 0xFFFF_FFFF and 0x8000_0000 → exactly 40 pulses; `prog_done_o` rises the cycle after pulse 40; later DATA writes are not shifted; CTRL `clear` drops `prog_done_o` and zeroes COUNT.
- DIV=3, `enable` written 0 after 5 pulses → no further pulses, COUNT=5, busy=0; re-enable with a new word → shifting restarts from that word's bit31.
- Chain loopback model (`ccff_tail_i` = head delayed by N pulses) → `last_tail` matches the model after each word; an out-of-window address access gets no ack.
